// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams a length-prefixed program from a byte source into instruction memory (checksum trailer enabled by INST_MEM_LOADER_CHECKSUM_EN)
module inst_mem_loader #(
  parameter int          ADDR_W         = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_stall,
  output logic              load_done,
  output logic              load_err
);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
`endif
  localparam int WL = ADDR_W + 1;
  state_t          r_state, w_nx;
  logic [31:0]     r_sr, r_gap;
  logic [1:0]      r_bcnt;
  logic [ADDR_W:0] r_wleft;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [31:0]     w_word;
  logic            w_byte4, w_len_bad, w_last, w_active, w_timeout;
  assign w_word    = {rx_data, r_sr[31:8]};
  assign w_byte4   = rx_valid && r_bcnt == 2'd3;
  assign w_len_bad = w_word == 32'd0 || {1'b0, w_word} > (33'd1 << ADDR_W);
  assign w_last    = r_we && r_wleft == '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_sum_ok;
  assign w_sum_ok = rx_data == r_sum;
  assign w_active = r_state == LEN || r_state == DATA || r_state == CHK;
`else
  assign w_active = r_state == LEN || r_state == DATA;
`endif
  assign w_timeout  = TIMEOUT_CYCLES != 0 && w_active && !rx_valid && r_gap == 32'(TIMEOUT_CYCLES - 1);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_stall = r_state != DONE;
  assign load_done  = r_state == DONE;
  assign load_err   = r_state == ERR;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_nx;
  // next-state: length check, word completion, optional checksum, byte-gap timeout
  always_comb begin
    w_nx = r_state;
    case (r_state)
      IDLE: w_nx = rx_valid ? LEN : IDLE;
      LEN:  w_nx = w_byte4 ? (w_len_bad ? ERR : DATA) : LEN;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      DATA: w_nx = w_last ? (rx_valid ? (w_sum_ok ? DONE : ERR) : CHK) : DATA;
      CHK:  w_nx = rx_valid ? (w_sum_ok ? DONE : ERR) : CHK;
`else
      DATA: w_nx = w_last ? DONE : DATA;
`endif
      default: w_nx = r_state;
    endcase
    if (w_timeout && w_nx == r_state) w_nx = ERR;
  end
  // datapath: byte assembly, word writes, address/remaining counters, gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_bcnt  <= '0;
      r_wleft <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_we  <= r_state == DATA && w_byte4;
      r_gap <= (rx_valid || !w_active) ? 32'd0 : r_gap + 32'd1;
      if (rx_valid && (r_state == IDLE || r_state == LEN || r_state == DATA)) begin
        r_sr   <= w_word;
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (r_state == LEN && w_byte4) r_wleft <= w_word[ADDR_W:0];
      if (r_state == DATA && w_byte4) begin
        r_wdata <= w_word;
        r_wleft <= r_wleft - WL'(1);
      end
      if (r_we && r_wleft != '0) r_addr <= r_addr + ADDR_W'(1);
    end
  end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  // running modulo-256 sum of every data byte
  always_ff @(posedge clk) r_sum <= rst ? 8'd0 : (r_state == DATA && rx_valid) ? r_sum + rx_data : r_sum;
`endif
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for the instruction memory loader
module tb_inst_mem_loader;
  localparam int AW = 4;
  logic          clk = 1'b0;
  logic          rst, rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we, core_stall, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [63:0]   sb[$];
  int            n_chk = 0, n_err = 0, cyc = 0, last_we = -1, addr_exp = 0;
  logic          gap_chk = 1'b0;
  logic [7:0]    tb_sum = 8'd0;

  inst_mem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_stall(core_stall), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // pop the scoreboard on every write pulse
  always @(negedge clk) if (mem_we !== 1'b0) begin
    if (sb.size() == 0) check("unexpected_we", {32'(mem_addr), mem_wdata}, 64'hDEAD);
    else check("write", {32'(mem_addr), mem_wdata}, sb.pop_front());
    if (gap_chk && last_we >= 0) check("we_spacing", 64'(cyc - last_we), 64'd4);
    last_we = cyc;
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(8'(n >> (8 * i)));
  endtask

  task automatic send_word(input logic [31:0] w);
    sb.push_back({32'(addr_exp), w});
    addr_exp++;
    for (int i = 0; i < 4; i++) begin
      tb_sum = tb_sum + 8'(w >> (8 * i));
      send(8'(w >> (8 * i)));
    end
  endtask

  task automatic finish_load(input string tag);
    check({tag, "_we_last"}, 64'(mem_we), 64'd1);
    check({tag, "_done_early"}, 64'(load_done), 64'd0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send(tb_sum);
`else
    idle(1);
`endif
    check({tag, "_done"}, 64'(load_done), 64'd1);
    check({tag, "_stall"}, 64'(core_stall), 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_stall", 64'(core_stall), 64'd1);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    rst = 1'b0;
    sb.delete();
    addr_exp = 0;
    tb_sum = 8'd0;
    last_we = -1;
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    do_reset();
    send_len(2);
    send_word(32'h13);
    send_word(32'h6F);
    finish_load("two_words");
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    check("done_ignores_rx", 64'(load_done), 64'd1);
    do_reset();
    send_len(0);
    check("len0_err", 64'(load_err), 64'd1);
    check("len0_stall", 64'(core_stall), 64'd1);
    idle(3);
    check("len0_err_sticky", 64'(load_err), 64'd1);
    do_reset();
    send_len(17);
    check("len_big_err", 64'(load_err), 64'd1);
    do_reset();
    send_len(16);
    check("len_max_ok", 64'(load_err), 64'd0);
    gap_chk = 1'b1;
    for (int i = 0; i < 16; i++) send_word(32'hA5000000 | 32'(i * 7));
    finish_load("len_max");
    do_reset();
    gap_chk = 1'b1;
    send_len(4);
    for (int i = 0; i < 4; i++) send_word($urandom);
    finish_load("b2b");
    gap_chk = 1'b0;
    do_reset();
    idle(40);
    check("idle_no_timeout", 64'(load_err), 64'd0);
    send_len(1);
    send(8'hAA);
    idle(15);
    check("gap15_no_err", 64'(load_err), 64'd0);
    idle(1);
    check("gap16_err", 64'(load_err), 64'd1);
    send(8'hBB); send(8'hCC); send(8'hDD);
    idle(2);
    check("err_ignores_rx", 64'(load_err), 64'd1);
    check("err_no_done", 64'(load_done), 64'd0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    do_reset();
    send_len(1);
    send_word(32'h04030201);
    check("sum_model", 64'(tb_sum), 64'h0A);
    finish_load("chk_ok");
    do_reset();
    send_len(1);
    send_word(32'h04030201);
    send(8'h0B);
    check("chk_bad_err", 64'(load_err), 64'd1);
    check("chk_bad_done", 64'(load_done), 64'd0);
`endif
    do_reset();
    send_len(3);
    send(8'h11); send(8'h22);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_stall", 64'(core_stall), 64'd1);
    send_len(1);
    send_word(32'hDEADBEEF);
    finish_load("after_rst");
    idle(3);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning the word-address width (instruction memory depth 2^ADDR_W words).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle cycles between bytes mid-load; 0 disables the timeout.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port rx_valid  input  1  single-cycle strobe: rx_data holds a received byte.
REQ-007 Port rx_data  input  8  received byte.
REQ-008 Port mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-009 Port mem_addr  output  ADDR_W  instruction memory word address.
REQ-010 Port mem_wdata  output  32  instruction word to write.
REQ-011 Port core_stall  output  1  holds the core fetch stage while high.
REQ-012 Port load_done  output  1  program loaded successfully, sticky.
REQ-013 Port load_err  output  1  load aborted, sticky.

Function
REQ-014 The stream SHALL be: 4-byte word count N, little-endian, then N words of 4 bytes each, little-endian, then an optional checksum byte (REQ-027).
REQ-015 The FSM SHALL have states IDLE, LEN, DATA, CHK, DONE, ERR; IDLE->LEN on the first rx_valid; LEN->DATA after byte 4; DATA->CHK or DONE after the final word; any state->ERR on fault.
REQ-016 N=0 or N>2^ADDR_W SHALL go to ERR in the cycle after the 4th length byte; no write occurs.
REQ-017 Bytes SHALL be assembled into a 32-bit shift register, first byte into bits 7:0.
REQ-018 mem_we SHALL pulse high for exactly one cycle, in the cycle after the rx_valid that carries the 4th byte of a word; mem_wdata and mem_addr are valid in that cycle.
REQ-019 mem_addr SHALL be 0 for word 0 and SHALL increment by 1 after each write; it never wraps within a load.
REQ-020 Without the checksum, the state SHALL become DONE one cycle after the final mem_we pulse. load_done SHALL assert and core_stall SHALL deassert in that same cycle.
REQ-021 The byte-gap counter SHALL clear on every rx_valid and count only in LEN, DATA and CHK. On reaching TIMEOUT_CYCLES (nonzero), the state SHALL go to ERR.
REQ-022 In DONE and ERR, rx_valid SHALL be ignored; both states SHALL be left only by rst.
REQ-023 In ERR, load_err SHALL be 1, core_stall SHALL stay 1, and mem_we SHALL stay 0.
REQ-024 The block SHALL accept back-to-back rx_valid on consecutive cycles.

Reset
REQ-025 On rst the state SHALL go to IDLE. Outputs SHALL reset to: mem_we=0, mem_addr=0, mem_wdata=0, core_stall=1, load_done=0, load_err=0. The byte and gap counters SHALL clear.
REQ-026 rst asserted mid-load SHALL abandon the load with no further writes; the next byte is treated as length byte 0.

Configuration
REQ-027 With macro INST_MEM_LOADER_CHECKSUM_EN defined:
- DATA SHALL go to CHK after the final mem_we.
- The next byte SHALL be compared with the 8-bit modulo-256 sum of all 4N data bytes.
- On match, DONE SHALL be entered the cycle after that byte; on mismatch, ERR.
REQ-028 Without INST_MEM_LOADER_CHECKSUM_EN, CHK and the sum logic SHALL be absent, and REQ-020 SHALL apply.

Verification
REQ-029 Stream 02 00 00 00, 13 00 00 00, 6F 00 00 00 (no checksum) -> mem_we pulses at addr 0 with 0x00000013 and at addr 1 with 0x0000006F. load_done=1 and core_stall=0 one cycle after the 2nd pulse.
REQ-030 Length 00 00 00 00 -> load_err=1 the cycle after the 4th byte; no mem_we; core_stall stays 1.
REQ-031 TIMEOUT_CYCLES=16; send 01 00 00 00, AA, then idle for 16 cycles -> ERR; later bytes are ignored.
REQ-032 CHECKSUM_EN, N=1, word bytes 01 02 03 04, trailer 0A -> write 0x04030201 at addr 0, then load_done. Repeat with trailer 0B -> load_err.
REQ-033 rst pulse after 6 bytes of a 3-word load, then a fresh 1-word stream -> a single write at addr 0, then load_done.
REQ-034 Bytes sent on consecutive cycles, N=4 -> four mem_we pulses exactly 4 cycles apart, at addrs 0..3.
